// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//
// UART receive engine with an integrated RX FIFO. The asynchronous rx line is
// synchronised, oversampled and deserialised (DATA_BITS data bits, LSB first,
// optional parity, one or two stop bits). Each received word is pushed into the
// FIFO together with its parity and framing error flags. The FIFO is drained
// through a valid/ready read port.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   - every bit sample is the 2-of-3 majority of rx at ticks
//               OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit
//   undefined - every bit sample is the single rx value at tick OVERSAMPLE/2
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   divider            baud tick period is divider+1 cycles
//   parity_en          a parity bit follows the data bits
//   parity_odd         1 = odd parity, 0 = even parity
//   stop2              two stop bits
//   flush              synchronous FIFO clear (also clears overrun_error)
//   rx                 asynchronous serial input
//   rd_valid/rd_ready  FIFO read handshake (pop on rd_valid & rd_ready)
//   rd_data            head word
//   rd_perr, rd_ferr   parity / framing error flags of the head word
//   fifo_empty         FIFO holds no entries
//   fifo_full          FIFO holds FIFO_DEPTH entries
//   fifo_level         current occupancy
//   overrun_error      sticky, set when a word was dropped on a full FIFO
//   busy               receiver FSM is not idle
//
// state     | meaning
// ----------+----------------------------------------------------------
// RX_IDLE   | waiting for a 1->0 transition on the synchronised rx
// RX_START  | confirming the start bit at its centre (false start -> idle)
// RX_SHIFT  | sampling DATA_BITS data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling one or two stop bits, push on the last one

module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_W-1:0]              divider,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic                          flush,
    input  logic                          rx,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun_error,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int EW = DATA_BITS + 2;

    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_SHIFT  = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    rx_state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Synchroniser and edge register
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;
    logic rx_fall;
    logic start_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall   = rx_prev & ~rx_sync;
    assign start_det = (state == RX_IDLE) & rx_fall;

    // ------------------------------------------------------------------
    // Baud tick and oversample phase counters
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic [OW-1:0]    os_cnt;

    // >= rather than == lets the counter recover if divider is lowered
    // below the running count; in normal operation both are identical.
    assign tick = (tick_cnt >= divider);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else if (start_det) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bit sampler. os_cnt == n-1 during the n-th tick of a bit period.
    // ------------------------------------------------------------------
    logic samp_now;
    logic samp_val;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [OW-1:0] SAMP_A = OW'(OVERSAMPLE / 2 - 2);
    localparam logic [OW-1:0] SAMP_B = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] SAMP_C = OW'(OVERSAMPLE / 2);

    logic maj_a, maj_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else if (tick) begin
            if (os_cnt == SAMP_A) maj_a <= rx_sync;
            if (os_cnt == SAMP_B) maj_b <= rx_sync;
        end
    end

    // Decision is taken on the third tick, using the two captured values.
    assign samp_now = tick & (os_cnt == SAMP_C);
    assign samp_val = (maj_a & maj_b) | (maj_a & rx_sync) | (maj_b & rx_sync);
`else
    localparam logic [OW-1:0] SAMP_B = OW'(OVERSAMPLE / 2 - 1);

    assign samp_now = tick & (os_cnt == SAMP_B);
    assign samp_val = rx_sync;
`endif

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_sr;
    logic [BW-1:0]        bit_cnt;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 stop_idx;
    logic                 shift_en;
    logic                 par_ld;
    logic                 stop_ld;
    logic                 push_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_ld    = 1'b0;
        stop_ld   = 1'b0;
        push_req  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_fall) state_nxt = RX_START;
            end
            RX_START: begin
                if (samp_now) state_nxt = samp_val ? RX_IDLE : RX_SHIFT;
            end
            RX_SHIFT: begin
                if (samp_now) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST)
                        state_nxt = parity_en ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (samp_now) begin
                    par_ld    = 1'b1;
                    state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (samp_now) begin
                    stop_ld = 1'b1;
                    if (!stop2 || stop_idx) begin
                        push_req  = 1'b1;
                        state_nxt = RX_IDLE;
                    end
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sr  <= '0;
            bit_cnt  <= '0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            if (start_det) begin
                bit_cnt  <= '0;
                perr_r   <= 1'b0;
                ferr_r   <= 1'b0;
                stop_idx <= 1'b0;
            end
            if (shift_en) begin
                data_sr <= {samp_val, data_sr[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_ld)
                perr_r <= ((^data_sr) ^ samp_val) != parity_odd;
            if (stop_ld) begin
                ferr_r   <= ferr_r | ~samp_val;
                stop_idx <= 1'b1;
            end
        end
    end

    assign busy = (state != RX_IDLE);

    // ------------------------------------------------------------------
    // RX FIFO: entry = {perr, ferr, data}
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_nxt;
    logic          empty_r, full_r, overrun_r;
    logic          pop, wr_en;

    // The last stop sample is folded in here since ferr_r only updates
    // on the same edge as the push.
    assign wr_entry = {perr_r, ferr_r | ~samp_val, data_sr};

    assign pop   = ~empty_r & rd_ready;
    assign wr_en = push_req & (~full_r | pop) & ~flush;

    always_comb begin
        level_nxt = level;
        case ({wr_en, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push_req & full_r & ~pop) overrun_r <= 1'b1;
            level   <= level_nxt;
            empty_r <= (level_nxt == '0);
            full_r  <= (level_nxt == LVL_FULL);
        end
    end

    assign head          = mem[rd_ptr];
    assign rd_data       = head[DATA_BITS-1:0];
    assign rd_ferr       = head[DATA_BITS];
    assign rd_perr       = head[DATA_BITS+1];
    assign rd_valid      = ~empty_r;
    assign fifo_empty    = empty_r;
    assign fifo_full     = full_r;
    assign fifo_level    = level;
    assign overrun_error = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo. Two instances share clock, reset and
// configuration: u0 is an 8-bit receiver with a 4-entry FIFO, u1 a 9-bit
// receiver. Serial frames are driven with a 16-cycle bit period (divider=0,
// OVERSAMPLE=16).

module tb_uart_rx_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] divider;
    logic        parity_en, parity_odd, stop2, flush;

    logic        rx0, rd_ready0;
    logic        rd_valid0, rd_perr0, rd_ferr0, empty0, full0, ovr0, busy0;
    logic [7:0]  rd_data0;
    logic [2:0]  level0;

    logic        rx1, rd_ready1;
    logic        rd_valid1, rd_perr1, rd_ferr1, empty1, full1, ovr1, busy1;
    logic [8:0]  rd_data1;
    logic [2:0]  level1;

    int vectors;
    int miscompares;
    int cyc;
    int t_fall;
    int rv_cyc;
    logic rv_q;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4), .DIV_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .divider(divider), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .flush(flush), .rx(rx0),
        .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_data(rd_data0),
        .rd_perr(rd_perr0), .rd_ferr(rd_ferr0), .fifo_empty(empty0),
        .fifo_full(full0), .fifo_level(level0), .overrun_error(ovr0), .busy(busy0)
    );

    uart_rx_fifo #(.DATA_BITS(9), .OVERSAMPLE(16), .FIFO_DEPTH(4), .DIV_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .divider(divider), .parity_en(parity_en),
        .parity_odd(parity_odd), .stop2(stop2), .flush(flush), .rx(rx1),
        .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_data(rd_data1),
        .rd_perr(rd_perr1), .rd_ferr(rd_ferr1), .fifo_empty(empty1),
        .fifo_full(full1), .fifo_level(level1), .overrun_error(ovr1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Records the cycle at which rd_valid of u0 rises.
    initial begin
        rv_q   = 1'b0;
        rv_cyc = 0;
    end
    always @(negedge clk) begin
        if (rd_valid0 && !rv_q) rv_cyc = cyc;
        rv_q = rd_valid0;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // Drives one frame; optionally pulses rd_ready0 for the single cycle in
    // which the word is pushed (154 negedges after the start-bit edge).
    task automatic send_frame(input int which, input logic [8:0] d, input int nd,
                              input bit pen, input bit pbit, input bit s1,
                              input bit two, input bit s2, input bit pop_at_push);
        logic [15:0] bits;
        int n;
        int k;
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
        if (pen) begin bits[n] = pbit; n++; end
        bits[n] = s1; n++;
        if (two) begin bits[n] = s2; n++; end
        k = 0;
        for (int b = 0; b < n; b++) begin
            drive_rx(which, bits[b]);
            if (b == 0) t_fall = cyc;
            for (int c = 0; c < 16; c++) begin
                if (pop_at_push) rd_ready0 = (k == 154);
                @(negedge clk);
                k++;
            end
        end
        drive_rx(which, 1'b1);
        rd_ready0 = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic pop0();
        rd_ready0 = 1'b1;
        @(negedge clk);
        rd_ready0 = 1'b0;
    endtask

    task automatic pop1();
        rd_ready1 = 1'b1;
        @(negedge clk);
        rd_ready1 = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int lat;
        vectors     = 0;
        miscompares = 0;
        t_fall      = 0;
        rst_n       = 1'b0;
        divider     = 16'd0;
        parity_en   = 1'b0;
        parity_odd  = 1'b0;
        stop2       = 1'b0;
        flush       = 1'b0;
        rx0         = 1'b1;
        rx1         = 1'b1;
        rd_ready0   = 1'b0;
        rd_ready1   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_rd_valid", rd_valid0, 0);
        check("rst_empty",    empty0,    1);
        check("rst_full",     full0,     0);
        check("rst_level",    level0,    0);
        check("rst_overrun",  ovr0,      0);
        check("rst_busy",     busy0,     0);
        check("rst_rd_data",  rd_data0,  0);
        check("rst_perr",     rd_perr0,  0);
        check("rst_ferr",     rd_ferr0,  0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic 8N1 frame
        send_frame(0, 9'h0A5, 8, 0, 0, 1, 0, 1, 0);
        lat = rv_cyc - t_fall;
        check("a5_latency_ok", (lat >= 154 && lat <= 157) ? 16'd1 : 16'd0, 1);
        check("a5_valid", rd_valid0, 1);
        check("a5_data",  rd_data0,  8'hA5);
        check("a5_perr",  rd_perr0,  0);
        check("a5_ferr",  rd_ferr0,  0);
        check("a5_level", level0,    1);
        check("a5_busy",  busy0,     0);
        pop0();
        check("a5_pop_empty", empty0, 1);

        // Even parity
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(0, 9'h007, 8, 1, 0, 1, 0, 1, 0);
        check("par0_data", rd_data0, 8'h07);
        check("par0_perr", rd_perr0, 1);
        check("par0_ferr", rd_ferr0, 0);
        pop0();
        send_frame(0, 9'h007, 8, 1, 1, 1, 0, 1, 0);
        check("par1_perr", rd_perr0, 0);
        pop0();
        parity_odd = 1'b1;
        send_frame(0, 9'h007, 8, 1, 0, 1, 0, 1, 0);
        check("odd_perr", rd_perr0, 0);
        pop0();
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // Framing error, single stop bit
        send_frame(0, 9'h03C, 8, 0, 0, 0, 0, 1, 0);
        check("ferr_data", rd_data0, 8'h3C);
        check("ferr_flag", rd_ferr0, 1);
        check("ferr_busy", busy0,    0);
        pop0();

        // Two stop bits, second one low
        stop2 = 1'b1;
        send_frame(0, 9'h05A, 8, 0, 0, 1, 1, 0, 0);
        check("stop2_data", rd_data0, 8'h5A);
        check("stop2_ferr", rd_ferr0, 1);
        pop0();
        send_frame(0, 9'h0C6, 8, 0, 0, 1, 1, 1, 0);
        check("stop2_ok_ferr", rd_ferr0, 0);
        pop0();
        stop2 = 1'b0;

        // False start: 5-cycle low glitch
        rx0 = 1'b0;
        repeat (5) @(negedge clk);
        rx0 = 1'b1;
        check("glitch_busy_hi", busy0, 1);
        repeat (40) @(negedge clk);
        check("glitch_busy_lo", busy0,     0);
        check("glitch_nopush",  rd_valid0, 0);

        // Overrun: five frames into a 4-entry FIFO
        send_frame(0, 9'h011, 8, 0, 0, 1, 0, 1, 0);
        send_frame(0, 9'h022, 8, 0, 0, 1, 0, 1, 0);
        send_frame(0, 9'h033, 8, 0, 0, 1, 0, 1, 0);
        check("ovr_no_early", ovr0, 0);
        send_frame(0, 9'h044, 8, 0, 0, 1, 0, 1, 0);
        send_frame(0, 9'h055, 8, 0, 0, 1, 0, 1, 0);
        check("ovr_full",    full0,    1);
        check("ovr_level",   level0,   4);
        check("ovr_flag",    ovr0,     1);
        check("ovr_head",    rd_data0, 8'h11);
        do_flush();
        check("flush_level", level0, 0);
        check("flush_ovr",   ovr0,   0);
        check("flush_empty", empty0, 1);

        // Push while full with a pop in the same cycle
        send_frame(0, 9'h061, 8, 0, 0, 1, 0, 1, 0);
        send_frame(0, 9'h062, 8, 0, 0, 1, 0, 1, 0);
        send_frame(0, 9'h063, 8, 0, 0, 1, 0, 1, 0);
        send_frame(0, 9'h064, 8, 0, 0, 1, 0, 1, 0);
        check("fill_full", full0, 1);
        send_frame(0, 9'h065, 8, 0, 0, 1, 0, 1, 1);
        check("pp_ovr",   ovr0,     0);
        check("pp_level", level0,   4);
        check("pp_full",  full0,    1);
        check("pp_head",  rd_data0, 8'h62);

        // Reset in the middle of a data bit
        rx0 = 1'b0;
        repeat (16) @(negedge clk);
        rx0 = 1'b1;
        repeat (16) @(negedge clk);
        rx0 = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", busy0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rx0 = 1'b1;
        check("mrst_valid", rd_valid0, 0);
        check("mrst_empty", empty0,    1);
        check("mrst_full",  full0,     0);
        check("mrst_level", level0,    0);
        check("mrst_ovr",   ovr0,      0);
        check("mrst_busy",  busy0,     0);
        check("mrst_data",  rd_data0,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(0, 9'h0C3, 8, 0, 0, 1, 0, 1, 0);
        check("post_rst_data",  rd_data0, 8'hC3);
        check("post_rst_level", level0,   1);
        check("post_rst_ferr",  rd_ferr0, 0);
        pop0();

        // 9-bit instance
        send_frame(1, 9'h1FF, 9, 0, 0, 1, 0, 1, 0);
        check("d9_valid", rd_valid1, 1);
        check("d9_data",  rd_data1,  9'h1FF);
        check("d9_ferr",  rd_ferr1,  0);
        pop1();
        send_frame(1, 9'h100, 9, 0, 0, 1, 0, 1, 0);
        check("d9_msb",   rd_data1,  9'h100);
        check("d9_level", level1,    1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
